universal_register: RTL and testbench



---
 rtl/universal_register.sv | 75 +++++++
 tb/tb_universal_register.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_register.sv
// universal_register: WIDTH-bit edge-triggered register with hold, load,
// shift, rotate and up/down count modes, asynchronous clear and preset,
// complementary output and a terminal-count flag for cascading counters.
module universal_register #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             _reset,
    input  logic             _preset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             tc
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_UP   = 3'b110;
    localparam logic [2:0] MODE_DOWN = 3'b111;

    logic [WIDTH-1:0] q_next;
    logic             preset_eff_n;

    // Preset only takes effect while reset is released. Gating it with
    // _reset means that releasing _reset while _preset is still low
    // produces a falling edge here, so the preset value appears at once
    // instead of the register sitting at RESET_VALUE until the next clock.
    assign preset_eff_n = _preset | ~_reset;

    // Next-state selection for one enabled clock edge; unknown modes hold.
    always_comb begin
        q_next = q;
        if (en) begin
            case (mode)
                MODE_HOLD: q_next = q;
                MODE_LOAD: q_next = d;
                MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
                MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
                MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
                MODE_UP:   q_next = q + {{(WIDTH-1){1'b0}}, 1'b1};
                MODE_DOWN: q_next = q - {{(WIDTH-1){1'b0}}, 1'b1};
                default:   q_next = q;
            endcase
        end
    end

    // State register: reset beats preset, both beat the clock.
    always_ff @(posedge clock or negedge _reset or negedge preset_eff_n) begin
        if (!_reset) begin
            q <= RESET_VALUE;
        end else if (!preset_eff_n) begin
            q <= PRESET_VALUE;
        end else begin
            q <= q_next;
        end
    end

    // Complement output and terminal count, flagged the cycle before a wrap.
    always_comb begin
        nq = ~q;
        tc = en & (((mode == MODE_UP) & (&q)) | ((mode == MODE_DOWN) & ~(|q)));
    end

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: an 8-bit instance driven with a directed
// sequence and random traffic, plus a 2-bit instance for wrap behaviour.
// Drivers push expected {q, nq, tc} into queues; monitors compare on negedge.
module tb_universal_register;

    logic       clock;
    logic       rst_n, pre_n, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] d, q, nq;
    logic       tc;

    logic       rst2_n, en2;
    logic [2:0] mode2;
    logic [1:0] q2, nq2;
    logic       tc2;

    logic [16:0] exp_q[$];
    string       lbl_q[$];
    logic [4:0]  exp2_q[$];
    string       lbl2_q[$];

    int passed = 0;
    int total  = 0;
    int m  = 0;   // reference state of the 8-bit register, 0..255
    int m2 = 0;   // reference state of the 2-bit register, 0..3

    universal_register #(.WIDTH(8)) dut (
        .clock(clock), ._reset(rst_n), ._preset(pre_n), .en(en), .mode(mode),
        .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q), .nq(nq), .tc(tc)
    );

    universal_register #(.WIDTH(2)) dut2 (
        .clock(clock), ._reset(rst2_n), ._preset(1'b1), .en(en2), .mode(mode2),
        .d(2'b00), .sin_l(1'b0), .sin_r(1'b0), .q(q2), .nq(nq2), .tc(tc2)
    );

    // Clock and initial input values.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: operations expressed as plain integer arithmetic.
    function automatic int model_next(input int v, input int md, input int dd,
                                      input int sl, input int sr, input int size);
        int half;
        half = size / 2;
        case (md)
            1: return dd % size;
            2: return (v * 2 + sr) % size;
            3: return v / 2 + sl * half;
            4: return (v * 2) % size + v / half;
            5: return v / 2 + (v % 2) * half;
            6: return (v + 1) % size;
            7: return (v + size - 1) % size;
            default: return v;
        endcase
    endfunction

    function automatic logic model_tc(input int v, input int e, input int md, input int size);
        return (e != 0) && ((md == 6 && v == size - 1) || (md == 7 && v == 0));
    endfunction

    // Apply one cycle of inputs at posedge+1, record the expected outputs
    // for the following negedge, then advance the model across the next edge.
    task automatic drive(input logic r, input logic p, input logic e, input logic [2:0] md,
                         input logic [7:0] dd, input logic sl, input logic sr, input string name);
        logic [7:0] mv;
        rst_n = r; pre_n = p; en = e; mode = md; d = dd; sin_l = sl; sin_r = sr;
        if (!r)      m = 0;
        else if (!p) m = 255;
        mv = m[7:0];
        exp_q.push_back({mv, ~mv, model_tc(m, int'(e), int'(md), 256)});
        lbl_q.push_back(name);
        if (r && p && e) m = model_next(m, int'(md), int'(dd), int'(sl), int'(sr), 256);
        @(posedge clock);
        #1;
    endtask

    task automatic drive2(input logic r, input logic e, input logic [2:0] md, input string name);
        logic [1:0] mv;
        rst2_n = r; en2 = e; mode2 = md;
        if (!r) m2 = 0;
        mv = m2[1:0];
        exp2_q.push_back({mv, ~mv, model_tc(m2, int'(e), int'(md), 4)});
        lbl2_q.push_back(name);
        if (r && e) m2 = model_next(m2, int'(md), 0, 0, 0, 4);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor for the 8-bit instance.
    initial begin
        logic [16:0] exp;
        string       name;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp  = exp_q.pop_front();
                name = lbl_q.pop_front();
                total++;
                if ({q, nq, tc} !== exp)
                    $display("FAIL %s: got q=%h nq=%h tc=%b, want q=%h nq=%h tc=%b",
                             name, q, nq, tc, exp[16:9], exp[8:1], exp[0]);
                else
                    passed++;
            end
        end
    end

    // Scoreboard monitor for the 2-bit instance.
    initial begin
        logic [4:0] exp;
        string      name;
        forever begin
            @(negedge clock);
            if (exp2_q.size() > 0) begin
                exp  = exp2_q.pop_front();
                name = lbl2_q.pop_front();
                total++;
                if ({q2, nq2, tc2} !== exp)
                    $display("FAIL %s: got q=%h nq=%h tc=%b, want q=%h nq=%h tc=%b",
                             name, q2, nq2, tc2, exp[4:3], exp[2:1], exp[0]);
                else
                    passed++;
            end
        end
    end

    // Stimulus.
    initial begin
        logic [7:0] rd;
        int         pick;
        rst_n = 1'b0; pre_n = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00;
        sin_l = 1'b0; sin_r = 1'b0;
        rst2_n = 1'b0; en2 = 1'b0; mode2 = 3'b000;
        @(posedge clock);
        #1;

        drive(0, 1, 0, 3'b000, 8'h00, 0, 0, "reset_state");
        // Asynchronous reset mid-count.
        drive(1, 1, 1, 3'b001, 8'h37, 0, 0, "pre_load_37");
        drive(1, 1, 1, 3'b110, 8'h00, 0, 0, "count_from_37");
        drive(0, 1, 1, 3'b110, 8'h00, 0, 0, "async_reset_mid_count");
        drive(1, 1, 1, 3'b110, 8'h00, 0, 0, "reset_released");
        drive(1, 1, 0, 3'b000, 8'h00, 0, 0, "count_after_reset");
        // Reset and preset together, released one at a time.
        drive(0, 0, 1, 3'b000, 8'h00, 0, 0, "reset_beats_preset");
        drive(1, 0, 1, 3'b000, 8'h00, 0, 0, "preset_after_reset_release");
        drive(1, 1, 1, 3'b000, 8'h00, 0, 0, "preset_value_holds");
        // Load, enable gating, shifts.
        drive(1, 1, 1, 3'b001, 8'hA5, 0, 0, "load_a5_issue");
        drive(1, 1, 0, 3'b110, 8'h00, 0, 0, "en_low_hold_1");
        drive(1, 1, 0, 3'b110, 8'h00, 0, 0, "en_low_hold_2");
        drive(1, 1, 0, 3'b110, 8'h00, 0, 0, "en_low_hold_3");
        drive(1, 1, 1, 3'b010, 8'h00, 0, 1, "shift_left_issue");
        drive(1, 1, 1, 3'b011, 8'h00, 0, 0, "shift_left_4b");
        drive(1, 1, 1, 3'b000, 8'h00, 0, 0, "shift_right_25");
        // Rotates.
        drive(1, 1, 1, 3'b001, 8'h81, 0, 0, "load_81_issue");
        drive(1, 1, 1, 3'b100, 8'h00, 0, 0, "loaded_81");
        drive(1, 1, 1, 3'b101, 8'h00, 0, 0, "rotate_left_03");
        drive(1, 1, 1, 3'b101, 8'h00, 0, 0, "rotate_right_81");
        drive(1, 1, 1, 3'b000, 8'h00, 0, 0, "rotate_right_c0");
        // Terminal count around the wrap in both directions.
        drive(1, 1, 1, 3'b001, 8'hFE, 0, 0, "load_fe_issue");
        drive(1, 1, 1, 3'b110, 8'h00, 0, 0, "tc_low_at_fe");
        drive(1, 1, 1, 3'b110, 8'h00, 0, 0, "tc_high_at_ff");
        drive(1, 1, 1, 3'b111, 8'h00, 0, 0, "tc_down_at_00");
        drive(1, 1, 1, 3'b000, 8'h00, 0, 0, "down_wrap_ff");
        drive(1, 1, 0, 3'b111, 8'h00, 0, 0, "tc_gated_by_en");

        // Randomized traffic with occasional asynchronous asserts.
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0:       rd = 8'h00;
                1:       rd = 8'hFF;
                2:       rd = 8'hFE;
                3:       rd = 8'h01;
                default: rd = 8'($urandom_range(0, 255));
            endcase
            drive(logic'($urandom_range(0, 24) != 0), logic'($urandom_range(0, 19) != 0),
                  logic'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rd,
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), "random");
        end
        drive(1, 1, 0, 3'b000, 8'h00, 0, 0, "random_final");

        // Two-bit counter wraps through all four states.
        drive2(0, 0, 3'b000, "w2_reset");
        drive2(1, 1, 3'b110, "w2_count_0");
        drive2(1, 1, 3'b110, "w2_count_1");
        drive2(1, 1, 3'b110, "w2_count_2");
        drive2(1, 1, 3'b110, "w2_count_3_tc");
        drive2(1, 1, 3'b111, "w2_wrapped_0");
        drive2(1, 1, 3'b000, "w2_down_wrap_3");

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d and %0d expectations left, want 0", exp_q.size(), exp2_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
